grid_vga_renderer: RTL



---
 rtl/grid_vga_renderer_if.sv | 21 ++
 rtl/grid_vga_renderer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/grid_vga_renderer_if.sv
// Play-field bus between the game-logic block and the VGA renderer:
// packed 256-bit grid in one direction, VGA pins and the frame marker in the other.
interface grid_vga_renderer_if;
  logic [255:0] grid_in;
  logic         hsync;
  logic         vsync;
  logic [3:0]   vga_r;
  logic [3:0]   vga_g;
  logic [3:0]   vga_b;
  logic         frame_start;

  modport master (
    output grid_in,
    input  hsync, vsync, vga_r, vga_g, vga_b, frame_start
  );

  modport slave (
    input  grid_in,
    output hsync, vsync, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/grid_vga_renderer.sv
// 16x16 grid to 640x480@60 VGA renderer, one grid snapshot per frame.
// Optional cell outlines are compiled in with the GRID_LINES_EN macro.
module grid_vga_renderer #(
  parameter int          CELL_SIZE  = 24,
  parameter int          X_OFFSET   = 128,
  parameter int          Y_OFFSET   = 48,
  parameter logic [11:0] FG_COLOR   = 12'hF80,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] GRID_COLOR = 12'h444,
  parameter int          H_VISIBLE  = 640,
  parameter int          H_FRONT    = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BACK     = 48,
  parameter int          V_VISIBLE  = 480,
  parameter int          V_FRONT    = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BACK     = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  grid_vga_renderer_if.slave   bus
);

  localparam int CW   = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam int PLAY = 16 * CELL_SIZE;

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] X_START  = 10'(X_OFFSET);
  localparam logic [9:0] X_END    = 10'(X_OFFSET + PLAY);
  localparam logic [9:0] Y_START  = 10'(Y_OFFSET);
  localparam logic [9:0] Y_END    = 10'(Y_OFFSET + PLAY);

  localparam logic [CW-1:0] CELL_LAST = CW'(CELL_SIZE - 1);
  localparam logic [CW-1:0] CELL_ONE  = CW'(1);

  logic [1:0]    div;
  logic          pix_en;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic [9:0]    hcount_nxt;
  logic [9:0]    vcount_nxt;
  logic          line_end;
  logic [CW-1:0] x_pix;
  logic [CW-1:0] y_pix;
  logic [3:0]    x_cell;
  logic [3:0]    y_cell;
  logic [255:0]  fb;
  logic          snap;
  logic          in_x;
  logic          in_y;
  logic          visible;
  logic [11:0]   colour;
  logic          hsync_q;
  logic          vsync_q;
  logic [11:0]   rgb_q;
  logic          frame_start_q;

  assign pix_en = (div == 2'd3);

  always_comb begin
    line_end   = (hcount == H_LAST);
    hcount_nxt = line_end ? 10'd0 : hcount + 10'd1;
    vcount_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    snap       = pix_en && (hcount == 10'd0) && (vcount == V_VIS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= 2'd0;
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else begin
      div <= div + 2'd1;
      if (pix_en) begin
        hcount <= hcount_nxt;
        if (line_end)
          vcount <= vcount_nxt;
      end
    end
  end

  // Cell sub-counters are primed one pixel ahead so they hold the
  // column/row of the pixel currently addressed by hcount/vcount.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pix  <= '0;
      x_cell <= 4'd0;
    end else if (pix_en) begin
      if (hcount_nxt == X_START) begin
        x_pix  <= '0;
        x_cell <= 4'd0;
      end else if (x_pix == CELL_LAST) begin
        x_pix  <= '0;
        x_cell <= x_cell + 4'd1;
      end else begin
        x_pix <= x_pix + CELL_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_pix  <= '0;
      y_cell <= 4'd0;
    end else if (pix_en && line_end) begin
      if (vcount_nxt == Y_START) begin
        y_pix  <= '0;
        y_cell <= 4'd0;
      end else if (y_pix == CELL_LAST) begin
        y_pix  <= '0;
        y_cell <= y_cell + 4'd1;
      end else begin
        y_pix <= y_pix + CELL_ONE;
      end
    end
  end

  always_comb begin
    in_x    = (hcount >= X_START) && (hcount < X_END);
    in_y    = (vcount >= Y_START) && (vcount < Y_END);
    visible = (hcount < H_VIS) && (vcount < V_VIS);
    colour  = BG_COLOR;
    if (in_x && in_y)
      colour = fb[{x_cell, y_cell}] ? FG_COLOR : BG_COLOR;
`ifdef GRID_LINES_EN
    if (in_x && in_y && ((x_pix == '0) || (y_pix == '0)))
      colour = GRID_COLOR;
    if ((hcount == X_END) && (vcount >= Y_START) && (vcount <= Y_END))
      colour = GRID_COLOR;
    if ((vcount == Y_END) && (hcount >= X_START) && (hcount <= X_END))
      colour = GRID_COLOR;
`endif
  end

  // frame_start is sampled every clk so it is high for exactly one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb            <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= snap;
      if (snap)
        fb <= bus.grid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 12'h000;
    end else if (pix_en) begin
      hsync_q <= !((hcount >= HS_START) && (hcount < HS_END));
      vsync_q <= !((vcount >= VS_START) && (vcount < VS_END));
      rgb_q   <= visible ? colour : 12'h000;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.frame_start = frame_start_q;

endmodule
